// File: rtl/window_3x3_generator_pkg.sv
// rtl/window_3x3_generator_pkg.sv - shared sizes, FSM encoding and column type for the 3x3 window generator
package window_3x3_generator_pkg;

    localparam int DEF_IMG_W = 512;
    localparam int DEF_IMG_H = 512;
    localparam int PIXEL_W   = 24;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_EOL   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    typedef struct packed {
        logic [PIXEL_W-1:0] top;
        logic [PIXEL_W-1:0] mid;
        logic [PIXEL_W-1:0] bot;
    } col_t;

endpackage

// File: rtl/window_3x3_generator_line_buffer.sv
// rtl/window_3x3_generator_line_buffer.sv - simple dual-port row RAM, synchronous read, old data on collision
module window_3x3_generator_line_buffer
    import window_3x3_generator_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int WIDTH = PIXEL_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The output register holds between reads; it forms the newest window column.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/window_3x3_generator.sv
// rtl/window_3x3_generator.sv - streaming 3x3 window generator with edge replication on all borders
module window_3x3_generator
    import window_3x3_generator_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               out_valid,
    output logic [PIXEL_W-1:0] out_pixel_1,
    output logic [PIXEL_W-1:0] out_pixel_2,
    output logic [PIXEL_W-1:0] out_pixel_3,
    output logic [PIXEL_W-1:0] out_pixel_4,
    output logic [PIXEL_W-1:0] out_pixel_5,
    output logic [PIXEL_W-1:0] out_pixel_6,
    output logic [PIXEL_W-1:0] out_pixel_7,
    output logic [PIXEL_W-1:0] out_pixel_8,
    output logic [PIXEL_W-1:0] out_pixel_9,
    output logic               out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_col, w_col_nxt;
    logic [RW-1:0]      r_row, w_row_nxt;
    logic               r_flush_go, w_flush_go_nxt;

    logic               w_accept, w_step, w_rd_en, w_emit, w_last;
    logic               w_left, w_right, w_top, w_bot;
    logic [CW-1:0]      w_rd_addr;

    col_t               r_col_a, r_col_b, w_col_c;
    logic [PIXEL_W-1:0] r_pix;
    logic [PIXEL_W-1:0] w_lb0_q, w_lb1_q;
    logic               r_lb1_we;
    logic [CW-1:0]      r_lb1_addr;
    logic               r_cl_left, r_cl_right, r_cl_top, r_cl_bot;
    logic               r_out_valid, r_out_last;
    col_t               w_l, w_m, w_r;

    assign in_ready = (r_state == ST_FILL) || (r_state == ST_RUN);
    assign w_accept = in_valid && in_ready;
    assign w_col_c  = '{top: w_lb1_q, mid: w_lb0_q, bot: r_pix};

    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_flush_go_nxt = r_flush_go;
        w_step         = 1'b0;
        w_rd_en        = 1'b0;
        w_rd_addr      = r_col;
        w_emit         = 1'b0;
        w_last         = 1'b0;
        w_left         = 1'b0;
        w_right        = 1'b0;
        w_top          = 1'b0;
        w_bot          = 1'b0;
        case (r_state)
            ST_FILL, ST_RUN: begin
                if (w_accept) begin
                    w_step  = 1'b1;
                    w_rd_en = 1'b1;
                    w_emit  = (r_state == ST_RUN) && (r_col != '0);
                    w_left  = (r_col == CW'(1));
                    w_top   = (r_row == RW'(1));
                    if (r_col == COL_LAST) begin
                        w_col_nxt = '0;
                        if (r_state == ST_FILL) begin
                            w_state_nxt = ST_RUN;
                            w_row_nxt   = RW'(1);
                        end else if (r_row == ROW_LAST) begin
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            w_state_nxt = ST_EOL;
                        end
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            ST_EOL: begin
                w_step      = 1'b1;
                w_emit      = 1'b1;
                w_right     = 1'b1;
                w_top       = (r_row == RW'(1));
                w_row_nxt   = r_row + 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
                w_step = 1'b1;
                w_emit = 1'b1;
                // First cycle closes row H-2 and primes column 0 of the replayed last row.
                if (!r_flush_go) begin
                    w_right        = 1'b1;
                    w_rd_en        = 1'b1;
                    w_rd_addr      = '0;
                    w_flush_go_nxt = 1'b1;
                end else begin
                    w_bot     = 1'b1;
                    w_left    = (r_col == '0);
                    w_rd_addr = r_col + 1'b1;
                    if (r_col == COL_LAST) begin
                        w_right        = 1'b1;
                        w_last         = 1'b1;
                        w_col_nxt      = '0;
                        w_row_nxt      = '0;
                        w_flush_go_nxt = 1'b0;
                        w_state_nxt    = ST_FILL;
                    end else begin
                        w_rd_en   = 1'b1;
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_col       <= '0;
            r_row       <= '0;
            r_flush_go  <= 1'b0;
            r_col_a     <= '0;
            r_col_b     <= '0;
            r_pix       <= '0;
            r_lb1_we    <= 1'b0;
            r_lb1_addr  <= '0;
            r_cl_left   <= 1'b0;
            r_cl_right  <= 1'b0;
            r_cl_top    <= 1'b0;
            r_cl_bot    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_flush_go  <= w_flush_go_nxt;
            r_out_valid <= w_emit;
            r_out_last  <= w_last;
            // LB1 takes the old LB0 word one cycle later, once the LB0 read has landed.
            r_lb1_we    <= w_accept;
            r_lb1_addr  <= r_col;
            if (w_accept) begin
                r_pix <= in_pixel;
            end
            if (w_step) begin
                r_col_a    <= r_col_b;
                r_col_b    <= w_col_c;
                r_cl_left  <= w_left;
                r_cl_right <= w_right;
                r_cl_top   <= w_top;
                r_cl_bot   <= w_bot;
            end
        end
    end

    window_3x3_generator_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W)) u_lb0 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_col),
        .i_wr_data (in_pixel),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_lb0_q)
    );

    window_3x3_generator_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W)) u_lb1 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (r_lb1_we),
        .i_wr_addr (r_lb1_addr),
        .i_wr_data (w_lb0_q),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_lb1_q)
    );

    always_comb begin
        w_l = r_cl_left  ? r_col_b : r_col_a;
        w_m = r_col_b;
        w_r = r_cl_right ? r_col_b : w_col_c;
    end

    assign out_pixel_1 = r_cl_top ? w_l.mid : w_l.top;
    assign out_pixel_2 = r_cl_top ? w_m.mid : w_m.top;
    assign out_pixel_3 = r_cl_top ? w_r.mid : w_r.top;
    assign out_pixel_4 = w_l.mid;
    assign out_pixel_5 = w_m.mid;
    assign out_pixel_6 = w_r.mid;
    assign out_pixel_7 = r_cl_bot ? w_l.mid : w_l.bot;
    assign out_pixel_8 = r_cl_bot ? w_m.mid : w_m.bot;
    assign out_pixel_9 = r_cl_bot ? w_r.mid : w_r.bot;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;

endmodule

// File: tb/tb_window_3x3_generator.sv
// tb/tb_window_3x3_generator.sv - randomized self-checking bench against a clamped-neighbourhood model
module tb_window_3x3_generator;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_pixel;
    logic        out_valid;
    logic        out_last;
    logic [23:0] out_pixel_1, out_pixel_2, out_pixel_3, out_pixel_4, out_pixel_5;
    logic [23:0] out_pixel_6, out_pixel_7, out_pixel_8, out_pixel_9;

    typedef struct packed {
        logic [215:0] taps;
        logic         last;
    } win_t;

    win_t         exp_q[$];
    logic [215:0] got_q[$];
    logic [23:0]  frame [H][W];
    int n_vec = 0, n_err = 0;
    int n_pulse = 0, n_last = 0, n_stall = 0;
    int p0, l0, s0, g0;

    localparam logic [215:0] RAMP_C00 = {24'h000000, 24'h000000, 24'h000100,
                                         24'h000000, 24'h000000, 24'h000100,
                                         24'h010000, 24'h010000, 24'h010100};
    localparam logic [71:0]  RAMP_C23_BOT = {24'h020200, 24'h020300, 24'h020300};

    window_3x3_generator #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid),
        .out_pixel_1(out_pixel_1), .out_pixel_2(out_pixel_2), .out_pixel_3(out_pixel_3),
        .out_pixel_4(out_pixel_4), .out_pixel_5(out_pixel_5), .out_pixel_6(out_pixel_6),
        .out_pixel_7(out_pixel_7), .out_pixel_8(out_pixel_8), .out_pixel_9(out_pixel_9),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [215:0] taps_now();
        return {out_pixel_1, out_pixel_2, out_pixel_3, out_pixel_4, out_pixel_5,
                out_pixel_6, out_pixel_7, out_pixel_8, out_pixel_9};
    endfunction

    task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; every cycle's outputs are compared here, #1 after the edge.
    task automatic tick();
        win_t         e;
        logic [215:0] act;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (!in_ready) n_stall++;
            act = taps_now();
            if (out_valid) begin
                n_pulse++;
                if (out_last) n_last++;
                got_q.push_back(act);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_window: got %h last=%0b, no window expected", act, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e.taps || out_last !== e.last) begin
                        n_err++;
                        $display("FAIL window: got %h last=%0b expected %h last=%0b",
                                 act, out_last, e.taps, e.last);
                    end
                end
            end else begin
                chk("last_without_valid", out_last, 1'b0);
            end
        end
    endtask

    task automatic prep_frame(input int kind, input logic [23:0] k);
        win_t w;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = (kind == 0) ? k : (kind == 1) ? {8'(r), 8'(c), 8'h00} : 24'($urandom);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                w.taps = '0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        w.taps = {w.taps[191:0], frame[clampi(r + dr, H - 1)][clampi(c + dc, W - 1)]};
                w.last = (r == H - 1) && (c == W - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic drive_pixel(input logic [23:0] px, input int r, input int c, input int gap);
        bit rdy;
        bit done;
        int guard;
        while ($urandom_range(99) < gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_pixel = px;
        guard = 0;
        done = 1'b0;
        while (!done) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 100) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL accept_timeout: pixel (%0d,%0d) not taken in 100 cycles", r, c);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        chk("emit_after_accept", out_valid, (r >= 1 && c >= 1));
    endtask

    task automatic drive_frame(input int gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                drive_pixel(frame[r][c], r, c, gap);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic snap();
        p0 = n_pulse;
        l0 = n_last;
        s0 = n_stall;
        g0 = got_q.size();
    endtask

    task automatic frame_checks(input int frames);
        chk("pulse_count", n_pulse - p0, frames * W * H);
        chk("last_count", n_last - l0, frames);
        chk("stall_count", n_stall - s0, frames * ((H - 2) + (W + 1)));
    endtask

    initial begin
        logic [215:0] t;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        tick();
        tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_taps", taps_now(), '0);
        rst_n = 1'b1;
        tick();

        snap();
        prep_frame(0, 24'hA5A5A5);
        drive_frame(0);
        drain();
        frame_checks(1);
        t = got_q[g0 + 11];
        chk("const_taps", t, {9{24'hA5A5A5}});

        snap();
        prep_frame(1, '0);
        chk("model_ramp_c00", exp_q[0].taps, RAMP_C00);
        drive_frame(0);
        drain();
        frame_checks(1);
        t = got_q[g0];
        chk("ramp_c00", t, RAMP_C00);
        t = got_q[g0 + 11];
        chk("ramp_c23_bottom", t[71:0], RAMP_C23_BOT);

        for (int f = 0; f < 6; f++) begin
            snap();
            prep_frame(2, '0);
            drive_frame(30);
            drain();
            frame_checks(1);
        end

        prep_frame(1, '0);
        for (int c = 0; c < W; c++) drive_pixel(frame[0][c], 0, c, 0);
        drive_pixel(frame[1][0], 1, 0, 0);
        drive_pixel(frame[1][1], 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 1'b0);
        chk("async_reset_in_ready", in_ready, 1'b1);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        snap();
        prep_frame(1, '0);
        drive_frame(0);
        drain();
        frame_checks(1);
        t = got_q[g0];
        chk("ramp_after_reset_c00", t, RAMP_C00);

        snap();
        prep_frame(0, 24'h111111);
        drive_frame(0);
        prep_frame(0, 24'h222222);
        drive_frame(0);
        drain();
        frame_checks(2);
        t = got_q[g0 + 11];
        chk("b2b_first_last", t, {9{24'h111111}});
        t = got_q[g0 + 12];
        chk("b2b_second_first", t, {9{24'h222222}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
